// File: rtl/load_store_unit_if.sv
// Handshake bundles for the load/store unit: core request/response side
// and data-memory side. master drives requests, slave serves them.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

interface load_store_unit_mem_if;
  logic        mem_cs;
  logic        mem_rd_wr;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output mem_cs, mem_rd_wr, mem_mask,
    output mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_cs, mem_rd_wr, mem_mask,
    input  mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, word-crossing accesses split in two.
// Ports: clk, rst (async high), core (req/rsp slave), mem (memory master).
module load_store_unit #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  load_store_unit_if.slave      core,
  load_store_unit_mem_if.master mem
);

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic        r_err;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word0;
  logic [31:0] r_word1;

  logic        w_hs;
  logic        w_legal;
  logic        w_req_split;
  logic        w_req_err;
  logic [1:0]  w_off;
  logic [2:0]  w_size;
  logic [2:0]  w_sh;
  logic [3:0]  w_smask;
  logic        w_split;
  logic [31:0] w_base;
  logic [31:0] w_dw;
  logic [31:0] w_ext;

  function automatic logic [2:0] size_of(input logic [1:0] sz);
    logic [2:0] s;
    unique case (1'b1)
      (sz == 2'b00): s = 3'd1;
      (sz == 2'b01): s = 3'd2;
      default:       s = 3'd4;
    endcase
    return s;
  endfunction

  // request-side legality, evaluated only at the handshake
  assign w_legal = core.req_we
    ? (core.req_funct3 inside {3'b000, 3'b001, 3'b010})
    : (core.req_funct3 inside {3'b000, 3'b001, 3'b010,
                               3'b100, 3'b101});
  assign w_req_split = ({1'b0, core.req_addr[1:0]}
                        + size_of(core.req_funct3[1:0])) > 3'd4;
  assign w_req_err = !w_legal
                  || (!ALLOW_MISALIGNED && w_req_split);
  assign w_hs = core.req_valid && (r_state == IDLE);

  // captured-request decode
  assign w_off   = r_addr[1:0];
  assign w_size  = size_of(r_f3[1:0]);
  assign w_sh    = 3'd4 - {1'b0, w_off};
  assign w_split = ({1'b0, w_off} + w_size) > 3'd4;
  assign w_base  = {r_addr[31:2], 2'b00};
  assign w_smask = (r_f3[1:0] == 2'b00) ? 4'b0001
                 : (r_f3[1:0] == 2'b01) ? 4'b0011
                 :                        4'b1111;

  // merged read data, already shifted down to byte 0
  assign w_dw = 32'({r_word1, r_word0} >> {w_off, 3'b000});

  always_comb begin
    w_ext = w_dw;
    unique case (1'b1)
      (r_f3 == 3'b000): w_ext = {{24{w_dw[7]}}, w_dw[7:0]};
      (r_f3 == 3'b001): w_ext = {{16{w_dw[15]}}, w_dw[15:0]};
      (r_f3 == 3'b100): w_ext = {24'd0, w_dw[7:0]};
      (r_f3 == 3'b101): w_ext = {16'd0, w_dw[15:0]};
      default:          w_ext = w_dw;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    core.req_ready = 1'b0;
    core.rsp_valid = 1'b0;
    core.rsp_rdata = 32'd0;
    core.rsp_err   = 1'b0;
    mem.mem_cs     = 1'b1;
    mem.mem_rd_wr  = 1'b1;
    mem.mem_mask   = 4'd0;
    mem.mem_addr   = 32'd0;
    mem.mem_wdata  = 32'd0;
    unique case (r_state)
      IDLE: begin
        core.req_ready = 1'b1;
        if (core.req_valid)
          w_next = w_req_err ? RESP : ACC0;
      end
      ACC0: begin
        mem.mem_cs    = 1'b0;
        mem.mem_rd_wr = !r_we;
        mem.mem_addr  = w_base;
        mem.mem_mask  = w_smask << w_off;
        mem.mem_wdata = r_wdata << {w_off, 3'b000};
        w_next        = w_split ? ACC1 : RESP;
      end
      ACC1: begin
        mem.mem_cs    = 1'b0;
        mem.mem_rd_wr = !r_we;
        mem.mem_addr  = w_base + 32'd4;
        mem.mem_mask  = w_smask >> w_sh;
        mem.mem_wdata = r_wdata >> {w_sh, 3'b000};
        w_next        = RESP;
      end
      RESP: begin
        core.rsp_valid = 1'b1;
        core.rsp_err   = r_err;
        core.rsp_rdata = (r_err || r_we) ? 32'd0 : w_ext;
        w_next         = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_f3    <= 3'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_word0 <= 32'd0;
      r_word1 <= 32'd0;
    end else begin
      if (w_hs) begin
        r_we    <= core.req_we;
        r_f3    <= core.req_funct3;
        r_addr  <= core.req_addr;
        r_wdata <= core.req_wdata;
        r_err   <= w_req_err;
      end
      if (r_state == ACC0) r_word0 <= mem.mem_rdata;
      if (r_state == ACC1) r_word1 <= mem.mem_rdata;
    end
  end

endmodule
